// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its return buffer.
package rf_writeback_arbiter_pkg;

  // Default register-file geometry for the vanilla core.
  localparam int rf_addr_width_gp = 5;
  localparam int rf_data_width_gp = 32;

  // Register zero is hard-wired; writes to it are dropped and it is never pending.
  localparam int rf_reg_zero_gp = 0;

  // One buffered remote/long-latency load return.
  typedef struct packed {
    logic [rf_addr_width_gp-1:0] addr;
    logic [rf_data_width_gp-1:0] data;
  } rf_wb_entry_s;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular FIFO holding buffered remote returns; exposes its occupancy
// so the arbiter can derive ready from registered state only.
module rf_wb_fifo #(
  parameter int width_p = 37,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       pop_i,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int count_width_lp = $clog2(els_p + 1);
  localparam logic [count_width_lp-1:0] els_lp = count_width_lp'(els_p);

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   wptr_r;
  logic [ptr_width_lp-1:0]   rptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      push_ok;
  logic                      pop_ok;

  assign empty_o = (count_r == '0);
  assign push_ok = push_i & (count_r != els_lp);
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_ok) wptr_r <= wptr_r + ptr_width_lp'(1);
      if (pop_ok)  rptr_r <= rptr_r + ptr_width_lp'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + count_width_lp'(1);
        2'b01:   count_r <= count_r - count_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Single write-port master for the 2R1W register file: merges pipeline
// writebacks with buffered remote returns, tracks outstanding remote loads,
// and forces a buffer slot when returns have waited too long.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int addr_width_p   = rf_addr_width_gp,
  parameter int data_width_p   = rf_data_width_gp,
  parameter int fifo_els_p     = 4,
  parameter int starve_limit_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    pipe_wb_v_i,
  input  logic [addr_width_p-1:0] pipe_wb_addr_i,
  input  logic [data_width_p-1:0] pipe_wb_data_i,
  input  logic                    remote_v_i,
  input  logic [addr_width_p-1:0] remote_addr_i,
  input  logic [data_width_p-1:0] remote_data_i,
  output logic                    remote_ready_o,
  input  logic                    issue_v_i,
  input  logic [addr_width_p-1:0] issue_addr_i,
  input  logic [addr_width_p-1:0] rs_addr_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    rs_pending_o,
  output logic                    rd_pending_o,
  output logic                    pipe_stall_o,
  output logic                    rf_cen_o,
  output logic                    rf_wen_o,
  output logic [addr_width_p-1:0] rf_write_addr_o,
  output logic [data_width_p-1:0] rf_write_data_o
);

  localparam int entry_width_lp  = addr_width_p + data_width_p;
  localparam int count_width_lp  = $clog2(fifo_els_p + 1);
  localparam int starve_width_lp = $clog2(starve_limit_p + 1);
  localparam int rf_els_lp       = 1 << addr_width_p;

  localparam logic [addr_width_p-1:0]    zero_addr_lp    = addr_width_p'(rf_reg_zero_gp);
  localparam logic [count_width_lp-1:0]  fifo_els_lp     = count_width_lp'(fifo_els_p);
  localparam logic [starve_width_lp-1:0] starve_limit_lp = starve_width_lp'(starve_limit_p);

  logic [entry_width_lp-1:0]  head_entry;
  logic [addr_width_p-1:0]    head_addr;
  logic [data_width_p-1:0]    head_data;
  logic [count_width_lp-1:0]  fifo_count;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;

  logic                       write_v;
  logic [addr_width_p-1:0]    write_addr;
  logic [data_width_p-1:0]    write_data;

  logic [rf_els_lp-1:0]       pending_r;
  logic [rf_els_lp-1:0]       pending_n;

  logic [starve_width_lp-1:0] starve_r;
  logic [starve_width_lp-1:0] starve_n;
  logic                       stall_r;
  logic                       stall_n;

  // Ready depends only on registered occupancy, so a full buffer refuses a
  // return even in a cycle where it is also being popped.
  assign remote_ready_o = ~reset_i & (fifo_count < fifo_els_lp);
  assign push           = remote_v_i & remote_ready_o;

  rf_wb_fifo #(
    .width_p (entry_width_lp),
    .els_p   (fifo_els_p)
  ) return_buffer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  ({remote_addr_i, remote_data_i}),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign head_addr = head_entry[entry_width_lp-1 -: addr_width_p];
  assign head_data = head_entry[data_width_p-1:0];

  // Write-port select: a stall cycle belongs to the buffer head, otherwise the
  // pipeline wins and the buffer drains into idle slots.
  always_comb begin
    pop        = 1'b0;
    write_v    = 1'b0;
    write_addr = pipe_wb_addr_i;
    write_data = pipe_wb_data_i;
    if (!reset_i) begin
      if (stall_r && !fifo_empty) begin
        pop = 1'b1;
      end else if (pipe_wb_v_i) begin
        write_v = 1'b1;
      end else if (!fifo_empty) begin
        pop = 1'b1;
      end
    end
    if (pop) begin
      write_v    = 1'b1;
      write_addr = head_addr;
      write_data = head_data;
    end
  end

  assign rf_cen_o        = ~reset_i;
  assign rf_wen_o        = write_v & (write_addr != zero_addr_lp);
  assign rf_write_addr_o = write_addr;
  assign rf_write_data_o = write_data;

  // Pending-register update: a retiring return clears its bit, a new issue sets
  // one, and the set is applied last so it wins on a same-address collision.
  always_comb begin
    pending_n = pending_r;
    if (pop && (head_addr != zero_addr_lp)) begin
      pending_n[head_addr] = 1'b0;
    end
    if (issue_v_i && (issue_addr_i != zero_addr_lp)) begin
      pending_n[issue_addr_i] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_n;
    end
  end

  assign rs_pending_o = (rs_addr_i != zero_addr_lp) & pending_r[rs_addr_i];
  assign rd_pending_o = (rd_addr_i != zero_addr_lp) & pending_r[rd_addr_i];

  // Starvation tracking: count cycles the head sits blocked; the stall is
  // raised together with the count reaching its limit, and the forced pop in
  // the stall cycle resets the count so the stall cannot repeat back to back.
  always_comb begin
    starve_n = starve_r;
    if (fifo_empty || pop) begin
      starve_n = '0;
    end else if (starve_r < starve_limit_lp) begin
      starve_n = starve_r + starve_width_lp'(1);
    end
    stall_n = (starve_n == starve_limit_lp);
  end

  // Starvation counter and registered stall.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_r <= '0;
      stall_r  <= 1'b0;
    end else begin
      starve_r <= starve_n;
      stall_r  <= stall_n;
    end
  end

  assign pipe_stall_o = stall_r;

`ifndef SYNTHESIS
  // Protocol checks on the surrounding pipeline and memory system.
  a_no_wb_in_stall: assert property (@(posedge clk_i) disable iff (reset_i)
    !(pipe_wb_v_i && pipe_stall_o));
  a_no_waw: assert property (@(posedge clk_i) disable iff (reset_i)
    !(pipe_wb_v_i && (pipe_wb_addr_i != zero_addr_lp) && pending_r[pipe_wb_addr_i]));
  a_no_double_issue: assert property (@(posedge clk_i) disable iff (reset_i)
    !(issue_v_i && (issue_addr_i != zero_addr_lp) && pending_r[issue_addr_i]));
  a_return_was_issued: assert property (@(posedge clk_i) disable iff (reset_i)
    !(remote_v_i && (remote_addr_i != zero_addr_lp) && !pending_r[remote_addr_i]));
  a_pipe_addr_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !(pipe_wb_v_i && $isunknown(pipe_wb_addr_i)));
  a_remote_addr_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !(remote_v_i && $isunknown(remote_addr_i)));
  a_issue_addr_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !(issue_v_i && $isunknown(issue_addr_i)));
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed cycle checks plus a
// scoreboard of accepted remote returns that must drain in arrival order.
module tb_rf_writeback_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        pipe_wb_v_i = 1'b0;
  logic [4:0]  pipe_wb_addr_i = '0;
  logic [31:0] pipe_wb_data_i = '0;
  logic        remote_v_i = 1'b0;
  logic [4:0]  remote_addr_i = '0;
  logic [31:0] remote_data_i = '0;
  logic        remote_ready_o;
  logic        issue_v_i = 1'b0;
  logic [4:0]  issue_addr_i = '0;
  logic [4:0]  rs_addr_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rs_pending_o;
  logic        rd_pending_o;
  logic        pipe_stall_o;
  logic        rf_cen_o;
  logic        rf_wen_o;
  logic [4:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;

  int assert_count = 0;
  int fail_count   = 0;
  logic [36:0] exp_q [$];
  logic prev_stall = 1'b0;

  rf_writeback_arbiter #(
    .addr_width_p   (5),
    .data_width_p   (32),
    .fifo_els_p     (4),
    .starve_limit_p (8)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .pipe_wb_v_i     (pipe_wb_v_i),
    .pipe_wb_addr_i  (pipe_wb_addr_i),
    .pipe_wb_data_i  (pipe_wb_data_i),
    .remote_v_i      (remote_v_i),
    .remote_addr_i   (remote_addr_i),
    .remote_data_i   (remote_data_i),
    .remote_ready_o  (remote_ready_o),
    .issue_v_i       (issue_v_i),
    .issue_addr_i    (issue_addr_i),
    .rs_addr_i       (rs_addr_i),
    .rd_addr_i       (rd_addr_i),
    .rs_pending_o    (rs_pending_o),
    .rd_pending_o    (rd_pending_o),
    .pipe_stall_o    (pipe_stall_o),
    .rf_cen_o        (rf_cen_o),
    .rf_wen_o        (rf_wen_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return mid-cycle.
  task automatic applyStimulus(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                               input logic rv, input logic [4:0] ra, input logic [31:0] rdat,
                               input logic iv, input logic [4:0] ia);
    @(posedge clk_i);
    #1;
    pipe_wb_v_i    = pv;
    pipe_wb_addr_i = pa;
    pipe_wb_data_i = pd;
    remote_v_i     = rv;
    remote_addr_i  = ra;
    remote_data_i  = rdat;
    issue_v_i      = iv;
    issue_addr_i   = ia;
    @(negedge clk_i);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Monitor: pipeline writes must go straight through; every other enabled
  // write must be the oldest accepted nonzero-address remote return.
  always @(negedge clk_i) begin
    if (reset_i) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("stall_twice", 64'(pipe_stall_o), 64'd0);
      prev_stall = pipe_stall_o;
      if (pipe_wb_v_i && !pipe_stall_o && pipe_wb_addr_i != 5'd0) begin
        checkOutput("pipe_wen",  64'(rf_wen_o), 64'd1);
        checkOutput("pipe_addr", 64'(rf_write_addr_o), 64'(pipe_wb_addr_i));
        checkOutput("pipe_data", 64'(rf_write_data_o), 64'(pipe_wb_data_i));
      end else if (rf_wen_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 64'(rf_wen_o), 64'd0);
        end else begin
          logic [36:0] exp_e;
          exp_e = exp_q.pop_front();
          checkOutput("remote_write", 64'({rf_write_addr_o, rf_write_data_o}), 64'(exp_e));
        end
      end
      if (remote_v_i && remote_ready_o && remote_addr_i != 5'd0)
        exp_q.push_back({remote_addr_i, remote_data_i});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_cen",   64'(rf_cen_o), 64'd0);
    checkOutput("reset_wen",   64'(rf_wen_o), 64'd0);
    checkOutput("reset_ready", 64'(remote_ready_o), 64'd0);
    checkOutput("reset_stall", 64'(pipe_stall_o), 64'd0);
    rs_addr_i = 5'd7;
    rd_addr_i = 5'd3;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_ready", 64'(remote_ready_o), 64'd1);
    checkOutput("idle_cen",   64'(rf_cen_o), 64'd1);
    checkOutput("idle_wen",   64'(rf_wen_o), 64'd0);
    checkOutput("idle_rs",    64'(rs_pending_o), 64'd0);
    checkOutput("idle_rd",    64'(rd_pending_o), 64'd0);

    // Issue to r7, then its return
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    checkOutput("rs_before_edge", 64'(rs_pending_o), 64'd0);
    rd_addr_i = 5'd7;
    idleCycle();
    checkOutput("rs_pending7", 64'(rs_pending_o), 64'd1);
    checkOutput("rd_pending7", 64'(rd_pending_o), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
    checkOutput("ret7_ready", 64'(remote_ready_o), 64'd1);
    checkOutput("ret7_no_bypass", 64'(rf_wen_o), 64'd0);
    idleCycle();
    checkOutput("ret7_wen",  64'(rf_wen_o), 64'd1);
    checkOutput("ret7_addr", 64'(rf_write_addr_o), 64'd7);
    checkOutput("ret7_data", 64'(rf_write_data_o), 64'hDEADBEEF);
    checkOutput("ret7_still_pending", 64'(rs_pending_o), 64'd1);
    idleCycle();
    checkOutput("ret7_cleared", 64'(rs_pending_o), 64'd0);

    // Starvation: r3 blocked behind continuous pipeline writes
    rs_addr_i = 5'd3;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h00003333, 1'b0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 5'(10 + i), 32'(32'hA0000000 + i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      checkOutput("starve_no_stall", 64'(pipe_stall_o), 64'd0);
    end
    idleCycle();
    checkOutput("starve_stall", 64'(pipe_stall_o), 64'd1);
    checkOutput("starve_wen",   64'(rf_wen_o), 64'd1);
    checkOutput("starve_addr",  64'(rf_write_addr_o), 64'd3);
    checkOutput("starve_data",  64'(rf_write_data_o), 64'h00003333);
    applyStimulus(1'b1, 5'd18, 32'hA0000008, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("starve_stall_drop", 64'(pipe_stall_o), 64'd0);
    checkOutput("starve_pending3", 64'(rs_pending_o), 64'd0);

    // Overflow: five returns into a four-deep buffer with the pipeline busy
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd11, 32'(32'hB0 + i), 1'b1, 5'(20 + i), 32'(32'hC0000000 + i), 1'b0, 5'd0);
      checkOutput("fill_ready", 64'(remote_ready_o), 64'd1);
    end
    applyStimulus(1'b1, 5'd11, 32'hB4, 1'b1, 5'd24, 32'hC0000004, 1'b0, 5'd0);
    checkOutput("full_ready", 64'(remote_ready_o), 64'd0);
    applyStimulus(1'b1, 5'd11, 32'hB5, 1'b1, 5'd24, 32'hC0000004, 1'b0, 5'd0);
    checkOutput("full_ready_hold", 64'(remote_ready_o), 64'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 32'hC0000004, 1'b0, 5'd0);
    checkOutput("full_pop_no_push", 64'(remote_ready_o), 64'd0);
    checkOutput("drain_first_addr", 64'(rf_write_addr_o), 64'd20);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 32'hC0000004, 1'b0, 5'd0);
    checkOutput("fifth_ready", 64'(remote_ready_o), 64'd1);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idleCycle();
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

    // Register zero
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h00005555, 1'b0, 5'd0);
    checkOutput("zero_ret_ready", 64'(remote_ready_o), 64'd1);
    idleCycle();
    checkOutput("zero_ret_wen", 64'(rf_wen_o), 64'd0);
    applyStimulus(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("zero_pipe_wen", 64'(rf_wen_o), 64'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h00001313, 1'b0, 5'd0);
    idleCycle();
    checkOutput("after_zero_wen",  64'(rf_wen_o), 64'd1);
    checkOutput("after_zero_addr", 64'(rf_write_addr_o), 64'd13);

    // Reset with three returns buffered
    rs_addr_i = 5'd5;
    rd_addr_i = 5'd9;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    applyStimulus(1'b1, 5'd11, 32'hE0, 1'b1, 5'd5, 32'h55555555, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd11, 32'hE1, 1'b1, 5'd6, 32'h66666666, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd11, 32'hE2, 1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0);
    checkOutput("pre_reset_rs", 64'(rs_pending_o), 64'd1);
    @(posedge clk_i);
    #1;
    reset_i     = 1'b1;
    pipe_wb_v_i = 1'b0;
    remote_v_i  = 1'b0;
    issue_v_i   = 1'b0;
    @(negedge clk_i);
    checkOutput("midreset_wen",   64'(rf_wen_o), 64'd0);
    checkOutput("midreset_ready", 64'(remote_ready_o), 64'd0);
    checkOutput("midreset_cen",   64'(rf_cen_o), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_ready", 64'(remote_ready_o), 64'd1);
    checkOutput("post_reset_rs",    64'(rs_pending_o), 64'd0);
    checkOutput("post_reset_rd",    64'(rd_pending_o), 64'd0);
    checkOutput("post_reset_wen",   64'(rf_wen_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("no_stale_write", 64'(rf_wen_o), 64'd0);
    end

    // Fresh return after reset is written the following cycle
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h12121212, 1'b0, 5'd0);
    idleCycle();
    checkOutput("post_reset_ret_addr", 64'(rf_write_addr_o), 64'd12);
    checkOutput("post_reset_ret_wen",  64'(rf_wen_o), 64'd1);
    idleCycle();
    checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Write-side master for the vanilla core's 2R1W register file. It merges same-cycle pipeline writebacks with buffered, out-of-order remote/long-latency load returns into the single register-file write port. It keeps a pending-register scoreboard so issue logic can stall on RAW/WAW hazards against outstanding loads, and it guarantees forward progress for buffered returns with a starvation counter.

Parameters:
addr_width_p, 5, register index width; the register file has 2**addr_width_p entries.
data_width_p, 32, write data width.
fifo_els_p, 4, remote-return buffer depth; power of two, at least 2.
starve_limit_p, 8, consecutive blocked cycles before the buffer forces a write slot.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
pipe_wb_v_i  in  1  pipeline writeback valid; accepted unconditionally
pipe_wb_addr_i  in  addr_width_p  pipeline destination register
pipe_wb_data_i  in  data_width_p  pipeline writeback data
remote_v_i  in  1  remote load return valid
remote_addr_i  in  addr_width_p  remote return destination register
remote_data_i  in  data_width_p  remote return data
remote_ready_o  out  1  buffer can accept; a return transfers when remote_v_i & remote_ready_o
issue_v_i  in  1  remote load issued; marks issue_addr_i pending
issue_addr_i  in  addr_width_p  destination of the issued remote load
rs_addr_i  in  addr_width_p  hazard query address
rd_addr_i  in  addr_width_p  hazard query address
rs_pending_o  out  1  rs_addr_i has an outstanding remote load
rd_pending_o  out  1  rd_addr_i has an outstanding remote load
pipe_stall_o  out  1  pipeline must not drive pipe_wb_v_i this cycle
rf_cen_o  out  1  register file enable
rf_wen_o  out  1  register file write enable
rf_write_addr_o  out  addr_width_p  register file write address
rf_write_data_o  out  data_width_p  register file write data

Behaviour:
- Reset (synchronous, active-high): buffer empty; scoreboard all zero; starvation count 0; pipe_stall_o=0.
- While reset_i is high: rf_cen_o=0, rf_wen_o=0, remote_ready_o=0. Reset asserted mid-operation discards buffered returns and clears all pending bits.
- rf_cen_o = ~reset_i.
- Buffer: FIFO, fifo_els_p entries, storing {addr, data}. remote_ready_o = ~reset_i & (count < fifo_els_p), combinational from the registered count only and never from remote_v_i. No push while full, including a same-cycle pop. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo fifo_els_p.
- Write-port select, combinational each cycle:
  - If pipe_wb_v_i: write the pipeline writeback.
  - Else if the buffer is non-empty: write and pop the head.
  - Else: no write.
- pipe_stall_o=1 gives the buffer head the port that cycle; pipe_wb_v_i must be 0 then.
- Minimum remote latency: a return accepted in cycle N is written no earlier than cycle N+1. There is no bypass from remote_*_i to rf_*_o.
- Register 0: a selected write with address 0 drives rf_wen_o=0, but a buffer head with address 0 is still popped. issue_v_i with address 0 sets no pending bit.
- Scoreboard, one bit per register:
  - issue_v_i sets bit[issue_addr_i] at the clock edge.
  - A buffer pop clears bit[head addr].
  - A same-cycle set and clear of the same address leaves the bit set (set wins).
  - rs_pending_o and rd_pending_o are combinational reads of the registered bits; index 0 always reads 0.
- Starvation counter (0..starve_limit_p):
  - Increments each cycle the buffer is non-empty and not popped.
  - Resets to 0 on any pop or when the buffer is empty.
  - When it reaches starve_limit_p, pipe_stall_o is registered high for exactly one cycle. The forced pop that cycle resets the counter.
  - pipe_stall_o is never high on two consecutive cycles.
- Simulation-only assertions, disabled during reset:
  - pipe_wb_v_i while pipe_stall_o.
  - pipe_wb_v_i to a nonzero register with its pending bit set (WAW).
  - issue_v_i to a nonzero register already pending.
  - remote_v_i to a nonzero register whose pending bit is clear.
  - An X on any address input while its valid is high.

Decomposition:
- Shared package holds the buffer entry typedef {addr, data} and the register-zero index constant.
- One sub-module, rf_wb_fifo: a parameterized FIFO with count output, push/pop and wrap-around pointers. Arbitration, scoreboard and starvation logic stay in the top module.

Test Plan:
- Reset then idle: rf_wen_o=0; remote_ready_o=1 the cycle after reset drops; all pending outputs 0.
- issue_v_i at addr 7; one cycle later rs_addr_i=7 gives rs_pending_o=1. Remote return addr 7, data 0xDEADBEEF with no pipeline traffic: written the next cycle and pending clears the cycle after that.
- Pipeline writes every cycle while return addr 3 is buffered: pipe_stall_o rises after 8 blocked cycles, addr 3 is written during the stall cycle, and the counter returns to 0.
- Five back-to-back returns with fifo_els_p=4 and the pipeline busy: remote_ready_o drops after four accepts. The fifth is accepted only after a pop, and writes drain in arrival order.
- Return to addr 0: popped with rf_wen_o=0. Pipeline write to addr 0 also gives rf_wen_o=0.
- Reset asserted with 3 entries buffered: after release the buffer is empty, the scoreboard is clear, and no stale writes occur.
